dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15, giving the number of clocks from request accept to response.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the block can accept a request.
REQ-007 SHALL have port req_we  input  1  1 selects store, 0 selects load.
REQ-008 SHALL have port req_funct3  input  3  RV32I load/store funct3 size code.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
REQ-011 SHALL have port rsp_valid  output  1  the response is available.
REQ-012 SHALL have port rsp_ready  input  1  the initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data after extension; 0 for stores and for errors.
REQ-014 SHALL have port rsp_err  output  1  the request was misaligned, had an illegal funct3, or was out of range.

Function
REQ-015 SHALL implement three states:
- IDLE: req_ready=1, rsp_valid=0.
- WAIT: req_ready=0, rsp_valid=0.
- RESP: req_ready=0, rsp_valid=1.
REQ-016 SHALL, in IDLE with req_valid=1 at a rising edge, capture req_we, req_funct3, req_addr and req_wdata, load the wait counter with LATENCY-1, and enter WAIT.
REQ-017 SHALL, in WAIT, decrement the counter each clock; when the counter is 0 it SHALL execute the captured access and enter RESP, so rsp_valid is first high exactly LATENCY clocks after the accepting edge.
REQ-018 SHALL, in RESP, hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1 at a rising edge, then return to IDLE.
REQ-019 SHALL NOT accept a new request on the same edge as the RESP handshake; the earliest next accept is the following edge.
REQ-020 SHALL decode legal loads by funct3 as: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
REQ-021 SHALL decode legal stores by funct3 as: 000 SB, 001 SH, 010 SW.
REQ-022 SHALL treat any other funct3 as an error.
REQ-023 SHALL use little-endian byte lanes: addr[1:0] selects the byte and addr[1] selects the halfword; SB/SH SHALL modify only the addressed lanes.
REQ-024 SHALL flag as misaligned LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0.
REQ-025 SHALL flag as out of range any request with addr[31:2] >= MEM_WORDS.
REQ-026 SHALL, for any error, set rsp_err=1 and rsp_rdata=0, and SHALL NOT write memory.
REQ-027 SHALL write memory exactly once per store, on the WAIT->RESP edge.
REQ-028 SHALL ignore req_* inputs while in WAIT or RESP.
REQ-029 SHALL return load data reflecting all stores completed before the load was accepted.

Reset
REQ-030 SHALL, on reset low, immediately (asynchronously) force IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and req_ready=1 once reset deasserts.
REQ-031 SHALL abort an in-flight request when reset asserts mid-operation: no write is performed if reset asserts before the WAIT->RESP edge, and no response is produced.
REQ-032 SHALL NOT clear memory contents on reset; contents are undefined until written.

Verification
REQ-033 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid high 2 clocks after each accept (LATENCY=2).
REQ-034 After REQ-033, SB addr 0x11 wdata 0x80, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-035 LH addr 0x13 -> rsp_err=1, rsp_rdata=0; SW addr 0x12 wdata 0x12345678 -> rsp_err=1, and a following LW 0x10 is unchanged.
REQ-036 LW addr 4*MEM_WORDS -> rsp_err=1; funct3=011 load -> rsp_err=1.
REQ-037 Hold rsp_ready=0 for 5 clocks in RESP -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0; rsp_ready=1 -> IDLE next clock, req_ready=1.
REQ-038 Accept SW addr 0x20 wdata 0x55AA55AA, assert reset low during WAIT, release, then LW 0x20 -> old contents returned; rsp_valid=0 throughout reset.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32I load/store with a fixed
// accept-to-response latency and a valid/ready response handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; req_ready=1
// ST_WAIT | request captured; latency timer counting down to zero
// ST_RESP | access done; response held until rsp_ready
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_capture;
  logic          w_execute;

  logic          r_we;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;

  // Storage is deliberately left without reset; contents survive rst.
  logic [31:0]   r_mem [MEM_WORDS];

  logic          w_f3_ok;
  logic          w_misalign;
  logic          w_range_err;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic [31:0]   w_store_word;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);

  // Next-state, timer reload/decrement and capture/execute strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_execute   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_execute   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, timer and captured request fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
    end
  end

  // Error classification of the captured request.
  always_comb begin
    w_f3_ok    = 1'b0;
    w_misalign = 1'b0;
    case (r_funct3)
      3'b000:         w_f3_ok = 1'b1;
      3'b001: begin
        w_f3_ok    = 1'b1;
        w_misalign = r_addr[0];
      end
      3'b010: begin
        w_f3_ok    = 1'b1;
        w_misalign = (r_addr[1:0] != 2'b00);
      end
      3'b100:         w_f3_ok = !r_we;
      3'b101: begin
        w_f3_ok    = !r_we;
        w_misalign = r_addr[0];
      end
      default:        w_f3_ok = 1'b0;
    endcase
  end

  assign w_range_err = ({2'b00, r_addr[31:2]} >= 32'(MEM_WORDS));
  assign w_err       = !w_f3_ok || w_misalign || w_range_err;
  assign w_idx       = r_addr[AW+1:2];
  assign w_word      = r_mem[w_idx];
  assign w_byte      = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half      = w_word[{r_addr[1], 4'b0000} +: 16];

  // Load lane extraction with sign or zero extension.
  always_comb begin
    w_load_data = 32'd0;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = w_word;
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = 32'd0;
    endcase
  end

  // Store merge: only the addressed byte/halfword lanes change.
  always_comb begin
    w_store_word = w_word;
    case (r_funct3[1:0])
      2'b00:   w_store_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_store_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_store_word = r_wdata;
    endcase
  end

  // Single write per legal store, on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (w_execute && r_we && !w_err) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

  // Response registers, loaded once and held through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (w_execute) begin
      rsp_err   <= w_err;
      rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load_data;
    end
  end

endmodule
